serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Framed serial receiver: start bit, N data bits and a stop bit are sampled on a bit-rate strobe and assembled into an N-bit word, which is held in a one-entry output buffer with a valid/ready handshake. It is the receive end of the team's parallel-load serial shifter links and sits between the line synchronizer and the word-consuming logic. It flags framing errors and overruns.

## Interface
- N, 8, data bits per frame; N ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- ena  in  1  bit strobe, one cycle per bit period at the bit centre; `sin` is sampled only when `ena`=1
- sin  in  1  serial line, already synchronized; idle high
- right  in  1  bit order: 1 = LSB first (bits enter at MSB, shift right); 0 = MSB first (bits enter at bit 0, shift left)
- q  out  N  received word
- valid  out  1  `q` holds an unconsumed word
- ready  in  1  consumer accepts `q` when `valid` & `ready`
- busy  out  1  a frame is in progress (state ≠ IDLE)
- ferr  out  1  one-cycle pulse: stop bit sampled low
- ovr  out  1  one-cycle pulse: good word dropped because the buffer was full

## Operation
- FSM states: IDLE, DATA, STOP, BREAK. All transitions happen on `ena`=1 only.
- IDLE: `sin`=0 → DATA. Clear the bit counter and the shift register. Latch `right` into `dir`; the latched value governs the whole frame.
- DATA: shift `sin` in per `dir` and increment the counter. The N-th data bit → STOP.
- STOP, `sin`=1: deliver the word and go to IDLE.
  - Buffer empty, or drained in the same cycle (`valid`&`ready`): load `q`, set `valid`.
  - Otherwise: pulse `ovr`, discard the new word, keep the old `q`/`valid`.
- STOP, `sin`=0: pulse `ferr`, discard the word, go to BREAK.
- BREAK: stay until `ena` with `sin`=1 → IDLE. This prevents a held-low line from being taken as repeated start bits.
- Handshake:
  - `valid` falls in the cycle after `valid`&`ready` unless a new word loads in that same edge. In that case `valid` stays 1 and `q` updates.
  - `q` is stable while `valid`=1.
  - `ready` while `valid`=0 has no effect.
- Bit counter is $clog2(N) bits wide. The last-bit compare is against N-1, with no wrap beyond N.

## Timing
- Reset values: `q`=0, `valid`=0, `busy`=0, `ferr`=0, `ovr`=0, FSM=IDLE, counter=0, shift register=0.
- Asserting reset mid-frame aborts the frame at once. The partial word is lost and no flag is raised.
- `busy` rises the cycle after the start-bit strobe. It falls the cycle after the stop-bit strobe (or after the BREAK exit).
- Latency: `valid`, `ferr` and `ovr` are registered and assert the cycle after the stop-bit `ena`.
- `ena` at consecutive clocks is legal: one bit per strobe, no minimum spacing.
- Frame length is N+2 strobes: start + N data + stop.
- `right` changes mid-frame are ignored until the next start bit.

## Structure
- Shared package `serial_rx_pkg`:
  - state enum `rx_state_t` {IDLE, DATA, STOP, BREAK}
  - constant for the counter width as a function of N
- Natural sub-module `sipo_shift`: N-bit serial-in shift register with clear, enable, direction and parallel output; instantiated once.
- The FSM, counter, output buffer and flag logic stay in the top module.

## Test plan
- Reset release, line idle high with `ena` every 4 clocks for 20 strobes → `valid`=`busy`=`ferr`=`ovr`=0 throughout.
- N=8, `right`=1, frame 0, 1,0,1,0,0,1,0,1, then 1 → `q`=8'hA5 and `valid`=1 the cycle after the stop strobe; `ready` pulse → `valid`=0 next cycle.
- Same bit sequence with `right`=0 → `q`=8'hA5 reversed = 8'hA5 (palindromic check). Then send 8'h01 MSB-first (0,0,0,0,0,0,0,1) → `q`=8'h01; LSB-first → `q`=8'h80.
- Two back-to-back frames 8'h3C, 8'hC3 with `ready`=0 → `q`=8'h3C, `ovr` pulses once at the second stop. Repeat with `ready`=1 in the second stop-bit cycle → `q`=8'hC3, `valid` stays 1, no `ovr`.
- Stop bit 0, then `sin` held low for 5 strobes, then high, then a frame of 8'h5A → one `ferr` pulse and no spurious start during the low period; `q`=8'h5A is delivered afterwards.
- Reset asserted after the 4th data bit → all outputs 0 asynchronously. A frame of 8'hFF after release → `q`=8'hFF with no residue from the aborted frame.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and sizing helpers for the framed serial word receiver.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Bit counter width for an N-bit frame; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// N-bit serial-in, parallel-out shift register with synchronous clear and
// selectable shift direction.
module sipo_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         right,
    input  logic         sin,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            // right: bits enter at the MSB (LSB-first line order)
            q <= right ? {sin, q[N-1:1]} : {q[N-2:0], sin};
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Framed serial receiver: start, N data bits, stop; one-entry output buffer
// with valid/ready handshake plus framing-error and overrun pulses.
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         sin,
    input  logic         right,
    output logic [N-1:0] q,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         ferr,
    output logic         ovr
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          dir_q;
    logic [N-1:0]  sr_q;

    logic start, shift, deliver, frame_err;
    logic load, drop;

    sipo_shift #(.N(N)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (shift),
        .right (dir_q),
        .sin   (sin),
        .q     (sr_q)
    );

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        shift     = 1'b0;
        deliver   = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ena && !sin) begin
                    start   = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ena) begin
                    shift = 1'b1;
                    if (cnt_q == LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (ena) begin
                    if (sin) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (ena && sin) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full buffer can still accept a word if it drains on the same edge.
    assign load = deliver && (!valid || ready);
    assign drop = deliver && valid && !ready;
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                cnt_q <= '0;
                dir_q <= right;
            end else if (shift && cnt_q != LAST) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            ferr <= frame_err;
            ovr  <= drop;
            if (load) begin
                q     <= sr_q;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed vector table, hand-written
// corner sequences and randomized frames against a word-level buffer model.
module tb_serial_word_rx;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b0;
    logic         sin = 1'b1;
    logic         right = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] q;
    logic         valid, busy, ferr, ovr;

    int checks = 0;
    int passed = 0;

    // Word-level model of the output buffer
    logic         mvalid = 1'b0;
    logic [7:0]   mq = 8'h00;

    typedef struct {
        logic [7:0] seq;   // line order: seq[7] is sent first
        logic       dir;
        logic       rdy;
        logic [7:0] eq;
        logic       ev;
        logic       eovr;
        logic       dr;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    serial_word_rx #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .sin   (sin),
        .right (right),
        .q     (q),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .ferr  (ferr),
        .ovr   (ovr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic strobe(input logic b, input logic rdy, input int gap);
        repeat (gap) @(negedge clk);
        sin   = b;
        ena   = 1'b1;
        ready = rdy;
        @(negedge clk);
        ena   = 1'b0;
        ready = 1'b0;
    endtask

    // Full frame; right is flipped after the start bit to prove it is latched.
    task automatic send(input logic [7:0] seq, input logic dir, input logic stopb,
                        input logic rdy, input int gap);
        right = dir;
        strobe(1'b0, 1'b0, gap);
        right = ~dir;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = N - 1; i >= 0; i--) strobe(seq[i], 1'b0, gap);
        strobe(stopb, rdy, gap);
    endtask

    task automatic drain();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        mvalid = 1'b0;
        chk("drain_valid", 32'(valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        logic       d, sb, rd, eovr, eferr;
        int         gap;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hC3, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_flags", {28'd0, valid, busy, ferr, ovr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle line, strobe every 4 clocks
        for (int i = 0; i < 20; i++) begin
            strobe(1'b1, 1'b0, 3);
            chk("idle_flags", {28'd0, valid, busy, ferr, ovr}, 32'd0);
        end

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].seq, tbl[i].dir, 1'b1, tbl[i].rdy, 1);
            chk("tbl_valid", 32'(valid), 32'(tbl[i].ev));
            chk("tbl_q", 32'(q), 32'(tbl[i].eq));
            chk("tbl_ovr", 32'(ovr), 32'(tbl[i].eovr));
            chk("tbl_ferr", 32'(ferr), 32'd0);
            chk("tbl_busy_end", 32'(busy), 32'd0);
            @(negedge clk);
            chk("tbl_ovr_pulse_end", 32'(ovr), 32'd0);
            if (tbl[i].dr) drain();
        end

        // Framing error, held-low line, recovery
        send(8'hF0, 1'b0, 1'b0, 1'b0, 0);
        chk("ferr_pulse", 32'(ferr), 32'd1);
        chk("ferr_busy", 32'(busy), 32'd1);
        chk("ferr_valid", 32'(valid), 32'd0);
        @(negedge clk);
        chk("ferr_pulse_end", 32'(ferr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            strobe(1'b0, 1'b0, 1);
            chk("break_hold", {29'd0, busy, valid, ferr}, 32'b100);
        end
        strobe(1'b1, 1'b0, 1);
        chk("break_exit", 32'(busy), 32'd0);
        send(8'h5A, 1'b0, 1'b1, 1'b0, 1);
        chk("after_break_q", 32'(q), 32'h5A);
        chk("after_break_valid", 32'(valid), 32'd1);

        // Reset mid-frame is asynchronous and leaves no residue
        right = 1'b0;
        strobe(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 0);
        rst = 1'b0;
        #1;
        chk("async_rst_q", 32'(q), 32'd0);
        chk("async_rst_flags", {28'd0, valid, busy, ferr, ovr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(8'hFF, 1'b0, 1'b1, 1'b0, 0);
        chk("post_rst_q", 32'(q), 32'hFF);
        chk("post_rst_valid", 32'(valid), 32'd1);
        mvalid = 1'b1;
        mq     = 8'hFF;

        // Randomized frames against the buffer model
        for (int k = 0; k < 60; k++) begin
            w   = 8'($urandom);
            d   = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 7) != 0);
            rd  = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            send(d ? rev8(w) : w, d, sb, rd, gap);
            eovr  = 1'b0;
            eferr = 1'b0;
            if (sb) begin
                if (!mvalid || rd) begin
                    mq     = w;
                    mvalid = 1'b1;
                end else begin
                    eovr = 1'b1;
                end
            end else begin
                eferr = 1'b1;
                if (mvalid && rd) mvalid = 1'b0;
            end
            chk("rnd_valid", 32'(valid), 32'(mvalid));
            if (mvalid) chk("rnd_q", 32'(q), 32'(mq));
            chk("rnd_ovr", 32'(ovr), 32'(eovr));
            chk("rnd_ferr", 32'(ferr), 32'(eferr));
            chk("rnd_busy", 32'(busy), 32'(!sb));
            if (!sb) begin
                repeat ($urandom_range(0, 3)) strobe(1'b0, 1'b0, gap);
                strobe(1'b1, 1'b0, gap);
                chk("rnd_break_exit", 32'(busy), 32'd0);
            end
            if ($urandom_range(0, 2) == 0) drain();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
